// File: rtl/cbm2_bus_pkg.sv
// Shared types and parameter checks for the CBM-II bus sequencer.
package cbm2_bus_pkg;

    localparam int ADDR_W = 25;

    typedef enum logic [1:0] {
        SLOT_VID,
        SLOT_CPU,
        SLOT_LD,
        SLOT_IDLE
    } busSlot_t;

    // True when the window layout fits inside one half-phase without overlap.
    function automatic bit seqParamsOk(int clkDiv, int cycleLen, int ldSlot, bit turboEn);
        bit ok;
        ok = (cycleLen >= 1) &&
             (clkDiv >= 2 * cycleLen + 1) &&
             (ldSlot >= cycleLen) &&
             (ldSlot + cycleLen <= clkDiv - 1);
        if (turboEn) begin
            ok = ok && (clkDiv >= ldSlot + 2 * cycleLen);
        end
        return ok;
    endfunction

endpackage

// File: rtl/cbm2_bus_sequencer_if.sv
// Loader handshake plus system-bus timing outputs of the bus sequencer.
interface cbm2_bus_sequencer_if;

    logic                              ld_req;
    logic                              ld_we;
    logic [cbm2_bus_pkg::ADDR_W-1:0]   ld_addr;
    logic [7:0]                        ld_data;
    logic                              ld_ack;
    logic [7:0]                        ld_q;
    logic [7:0]                        ram_q;

    logic                              phase;
    logic                              vidCycle;
    logic                              cpuCycle;
    logic                              ldCycle;
    logic [cbm2_bus_pkg::ADDR_W-1:0]   ld_sys_addr;
    logic                              ld_sys_we;
    logic [7:0]                        ld_sys_data;
    logic                              cpu_ce;
    logic                              cpu_halted;

    modport master (
        output ld_req, ld_we, ld_addr, ld_data, ram_q,
        input  ld_ack, ld_q, phase, vidCycle, cpuCycle, ldCycle,
               ld_sys_addr, ld_sys_we, ld_sys_data, cpu_ce, cpu_halted
    );

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_data, ram_q,
        output ld_ack, ld_q, phase, vidCycle, cpuCycle, ldCycle,
               ld_sys_addr, ld_sys_we, ld_sys_data, cpu_ce, cpu_halted
    );

endinterface

// File: rtl/cbm2_slot_timer.sv
// Half-phase slot counter, phase toggle and registered window decode.
// CBM2_SEQ_TURBO_EN adds a phase-0 CPU window when turbo is set.
module cbm2_slot_timer
    import cbm2_bus_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int CYCLE_LEN = 4,
    parameter int LD_SLOT   = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic turbo,
    input  logic haltNext,
    output logic phase,
    output logic vidCycle,
    output logic cpuCycle,
    output logic cpuCe,
    output logic haltSample,
    output logic ldEnter,
    output logic ldSlotNext,
    output logic ldLastNext
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CYC      = CW'(CYCLE_LEN);
    localparam logic [CW-1:0] LD_FIRST = CW'(LD_SLOT);
    localparam logic [CW-1:0] LD_END   = CW'(LD_SLOT + CYCLE_LEN - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] nextCount;
    logic          nextPhase;
    logic          armed;
    logic          wrap;
    logic          turboAct;
    busSlot_t      nextSlot;

    // The first clock after reset release is count 0, so the counter holds
    // at 0 until armed.
    assign wrap      = armed && (count == LAST);
    assign nextCount = (!armed || wrap) ? '0 : count + CW'(1);
    assign nextPhase = wrap ? ~phase : phase;

`ifdef CBM2_SEQ_TURBO_EN
    localparam logic [CW-1:0] VID_T_FIRST = CW'(LD_SLOT + CYCLE_LEN);

    logic turboQ;
    logic turboNext;

    assign turboNext = (wrap || !armed) ? turbo : turboQ;
    assign turboAct  = turboNext && !haltNext;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) turboQ <= 1'b0;
        else          turboQ <= turboNext;
    end
`else
    logic unusedTurbo;
    assign unusedTurbo = turbo;
    assign turboAct    = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, otherwise an
    // untaken branch holds the old value and a latch is inferred.
    always_comb begin
        nextSlot = SLOT_IDLE;
        if (!nextPhase && !turboAct && (nextCount < CYC)) begin
            nextSlot = SLOT_VID;
`ifdef CBM2_SEQ_TURBO_EN
        end else if (!nextPhase && turboAct && ((nextCount - VID_T_FIRST) < CYC)) begin
            nextSlot = SLOT_VID;
`endif
        end else if ((nextPhase || turboAct) && !haltNext && (nextCount < CYC)) begin
            nextSlot = SLOT_CPU;
        end else if ((nextCount - LD_FIRST) < CYC) begin
            nextSlot = SLOT_LD;
        end
    end

    assign haltSample = wrap && !phase;
    assign ldEnter    = armed && (nextCount == LD_FIRST);
    assign ldSlotNext = (nextSlot == SLOT_LD);
    assign ldLastNext = (nextCount == LD_END);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            phase    <= 1'b0;
            armed    <= 1'b0;
            vidCycle <= 1'b0;
            cpuCycle <= 1'b0;
            cpuCe    <= 1'b0;
        end else begin
            armed    <= 1'b1;
            count    <= nextCount;
            phase    <= nextPhase;
            vidCycle <= (nextSlot == SLOT_VID);
            cpuCycle <= (nextSlot == SLOT_CPU);
            cpuCe    <= (nextPhase || turboAct) && !haltNext && (nextCount == LAST);
        end
    end

endmodule

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II system bus sequencer: slot timing, CPU halt and loader handshake.
// CBM2_SEQ_TURBO_EN enables the optional phase-0 CPU window (turbo input).
module cbm2_bus_sequencer
    import cbm2_bus_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int CYCLE_LEN = 4,
    parameter int LD_SLOT   = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ld_active,
    input  logic                 turbo,
    cbm2_bus_sequencer_if.slave  bus
);

`ifdef CBM2_SEQ_TURBO_EN
    localparam bit TURBO_EN = 1'b1;
`else
    localparam bit TURBO_EN = 1'b0;
`endif

    if (!seqParamsOk(CLK_DIV, CYCLE_LEN, LD_SLOT, TURBO_EN)) begin : gBadParams
        $error("cbm2_bus_sequencer: illegal CLK_DIV/CYCLE_LEN/LD_SLOT combination");
    end

    logic              phase;
    logic              vidCycle;
    logic              cpuCycle;
    logic              cpuCe;
    logic              haltSample;
    logic              ldEnter;
    logic              ldSlotNext;
    logic              ldLastNext;

    logic              halted;
    logic              haltNext;

    logic              ldOpen;
    logic              openNext;
    logic              ldWeQ;
    logic [ADDR_W-1:0] ldAddrQ;
    logic [7:0]        ldDataQ;
    logic              ldSysWe;
    logic              ldAck;
    logic [7:0]        ldQ;

    cbm2_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .CYCLE_LEN (CYCLE_LEN),
        .LD_SLOT   (LD_SLOT)
    ) u_timer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .turbo      (turbo),
        .haltNext   (haltNext),
        .phase      (phase),
        .vidCycle   (vidCycle),
        .cpuCycle   (cpuCycle),
        .cpuCe      (cpuCe),
        .haltSample (haltSample),
        .ldEnter    (ldEnter),
        .ldSlotNext (ldSlotNext),
        .ldLastNext (ldLastNext)
    );

    // Halt changes only at the end of the video half, so a started CPU
    // window always runs to completion.
    assign haltNext = haltSample ? ld_active : halted;

    // The slot opens on a sampled request and stays open to its last clock
    // even if the requester drops ld_req early.
    assign openNext = ldEnter ? bus.ld_req : (ldSlotNext && ldOpen);

    // NOTE: the latched loader payload is reset along with the control state
    // because it drives module outputs directly; plain storage need not be.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            halted  <= 1'b0;
            ldOpen  <= 1'b0;
            ldWeQ   <= 1'b0;
            ldAddrQ <= '0;
            ldDataQ <= '0;
            ldSysWe <= 1'b0;
            ldAck   <= 1'b0;
            ldQ     <= '0;
        end else begin
            halted  <= haltNext;
            ldOpen  <= openNext;
            if (ldEnter && bus.ld_req) begin
                ldWeQ   <= bus.ld_we;
                ldAddrQ <= bus.ld_addr;
                ldDataQ <= bus.ld_data;
            end
            ldSysWe <= openNext && (ldEnter ? bus.ld_we : ldWeQ);
            ldAck   <= openNext && ldLastNext;
            if (ldAck && !ldWeQ) begin
                ldQ <= bus.ram_q;
            end
        end
    end

    assign bus.phase       = phase;
    assign bus.vidCycle    = vidCycle;
    assign bus.cpuCycle    = cpuCycle;
    assign bus.cpu_ce      = cpuCe;
    assign bus.cpu_halted  = halted;
    assign bus.ldCycle     = ldOpen;
    assign bus.ld_sys_addr = ldAddrQ;
    assign bus.ld_sys_data = ldDataQ;
    assign bus.ld_sys_we   = ldSysWe;
    assign bus.ld_ack      = ldAck;
    assign bus.ld_q        = ldQ;

endmodule

// File: doc/cbm2_bus_sequencer.md
Name: cbm2_bus_sequencer

Overview:
- Time-slot sequencer and arbiter for the shared CBM-II system bus (systemAddr/systemWe/ramData path).
- Derives the 1 MHz `phase` from `clk_sys`. Issues `vidCycle` and `cpuCycle` strobes and the CPU clock-enable.
- Inserts ROM/RAM-loader (download) accesses into a dedicated slot in each half-phase.
- Halts the CPU while a download is active.
- Sits between the top level (CPU, VIC/CRTC, ioctl loader) and the bus decode logic.

Parameters:
- CLK_DIV, 16: `clk_sys` clocks per half-phase; must be >= 2*CYCLE_LEN+1.
- CYCLE_LEN, 4: clocks a cycle strobe stays high, i.e. memory access window.
- LD_SLOT, 8: slot count at which the loader window opens; requires LD_SLOT >= CYCLE_LEN and LD_SLOT+CYCLE_LEN <= CLK_DIV-1.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ld_active  in  1  download in progress; halts CPU
- ld_req  in  1  loader access request (level)
- ld_we  in  1  loader write
- ld_addr  in  25  loader address
- ld_data  in  8  loader write data
- ld_ack  out  1  one-clock completion pulse
- ld_q  out  8  read data captured for loader
- ram_q  in  8  bus read data (ramData)
- phase  out  1  0 = video half, 1 = CPU half
- vidCycle  out  1  video access window
- cpuCycle  out  1  CPU access window
- ldCycle  out  1  loader access window
- ld_sys_addr  out  25  loader address presented during ldCycle
- ld_sys_we  out  1  loader write enable, qualified by ldCycle
- ld_sys_data  out  8  loader write data
- cpu_ce  out  1  CPU clock-enable pulse
- cpu_halted  out  1  CPU currently halted
- turbo  in  1  see Optional Feature; ignored when the feature is compiled out

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0, phase = 0, halted = 0.
  - All strobes, ld_ack, ld_q, ld_sys_* = 0.
- Outputs are registered.
  - "Count n" = the clock in which the internal counter holds n.
  - Strobes decoded from count n appear on the outputs in that same clock; the decode is registered from the count n-1 state.
  - The first count-0 clock is the first edge after reset release.
- Counter runs 0..CLK_DIV-1 and wraps. `phase` toggles on every wrap.
- phase=0: vidCycle high for counts 0..CYCLE_LEN-1, every half-phase, unconditionally.
- phase=1:
  - cpuCycle high for counts 0..CYCLE_LEN-1, unless halted.
  - cpu_ce is a single pulse at count CLK_DIV-1, unless halted.
- Halt:
  - ld_active is sampled only at count CLK_DIV-1 of phase 0, and updates `halted` there.
  - A CPU cycle is therefore never truncated.
  - cpu_halted reflects `halted`.
- Loader slot, either phase:
  - At count LD_SLOT, if ld_req=1, latch ld_addr, ld_we, ld_data and open the slot.
  - ldCycle is high for counts LD_SLOT..LD_SLOT+CYCLE_LEN-1.
  - ld_sys_* drive the latched values; ld_sys_we = latched we & ldCycle.
  - At the last slot clock: ld_q <= ram_q on reads (held otherwise) and ld_ack pulses for one clock.
  - If ld_req is low at count LD_SLOT, the slot is idle: no ldCycle, no ack.
- Loader handshake:
  - The requester holds ld_req and its payload until ld_ack.
  - It may present the next request in the clock after ack; that request is served in the next half-phase's slot.
  - Maximum throughput: 2 accesses per phase pair.
  - ld_req dropping mid-slot does not abort the slot; the ack is still issued.
- Strobe windows never overlap:
  - At most one of vidCycle/cpuCycle/ldCycle is high in any clock.
  - This is a bench invariant.
- Loader accesses are allowed while the CPU is not halted. The arbiter does not block them; exclusivity is by time slot.
- Reset mid-slot: all strobes drop immediately (async), the latched request is discarded, and no ack is issued.

Optional Feature:
- Macro: CBM2_SEQ_TURBO_EN.
- Defined:
  - When turbo=1 and the CPU is not halted, phase 0 also gets a CPU window: cpuCycle at counts 0..CYCLE_LEN-1 and cpu_ce at count CLK_DIV-1.
  - vidCycle then moves to counts LD_SLOT+CYCLE_LEN..LD_SLOT+2*CYCLE_LEN-1 of phase 0.
  - This requires CLK_DIV >= LD_SLOT+2*CYCLE_LEN; elaboration error otherwise.
  - turbo is sampled only at phase wrap.
- Undefined: the turbo port is ignored and the schedule is exactly as above.

Decomposition:
- Package cbm2_bus_pkg holds:
  - localparam ADDR_W = 25;
  - slot enum {SLOT_VID, SLOT_CPU, SLOT_LD, SLOT_IDLE};
  - the parameter-legality check function.
- One sub-module, cbm2_slot_timer: counter, phase and window decode. The top level holds the halt and loader handshake logic.

Test Plan (defaults 16/4/8):
- Free run, ld_req=0, ld_active=0:
  - phase period is 32 clocks.
  - vidCycle at counts 0-3 of phase 0; cpuCycle at counts 0-3 of phase 1.
  - cpu_ce once per 32 clocks at count 15 of phase 1.
  - No overlap over 10k clocks.
- Loader write: ld_req=1, addr=0x0FE000, data=0xA5, asserted at count 3 of phase 1.
  - ldCycle at counts 8-11; ld_sys_we high for those 4 clocks; ld_ack at count 11.
- Loader read with ram_q=0x3C during the slot: ld_q=0x3C from the clock after the ack.
  - Back-to-back request immediately after the ack: served in the next half-phase, 16 clocks later.
- ld_active rises mid phase 1:
  - The current cpuCycle completes.
  - Halt takes effect at the next phase-0 count 15; no cpuCycle/cpu_ce until release at a later phase-0 count 15.
- reset_n low at count 9 of an active loader slot: all outputs 0 immediately, no ld_ack; after release, the first vidCycle starts at count 0.
- With CBM2_SEQ_TURBO_EN, turbo=1: two cpu_ce per 32 clocks, vidCycle at phase-0 counts 12-15, and no strobe overlap.
